// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity-mode encodings, receiver
// state enum and the baud-tick divider helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Tick index (0..15) at which the start bit is re-checked: roughly mid-bit.
  localparam int START_SAMPLE_TICK = 7;

  // 16x oversampling divider, truncated and never below one clock.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * 16);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered head output; pointers carry one extra
// wrap bit so full and empty are distinguishable.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [AW-1:0]    rd_next_idx;
  logic             do_push, do_pop;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count       = CW'(wr_ptr_q - rd_ptr_q);
  assign do_pop      = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push     = push && (!full || do_pop);
  assign rd_next_idx = rd_ptr_q[AW-1:0] + 1'b1;
  assign rdata       = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Head register shows the oldest entry; it keeps its value once drained.
    if (do_pop) begin
      if (count > CW'(1))  head_d = mem_q[rd_next_idx];
      else if (do_push)    head_d = wdata;
    end else if (do_push && empty) begin
      head_d = wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampling) feeding a FIFO with cts flow control and a
// sticky overrun flag. Define UART_RX_PARITY_EN to enable the parity bit.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_MARGIN = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                serial_in,
  input  logic [1:0]                          parity_mode,
  input  logic                                data_read,
  input  logic                                clear_err,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                parity_err,
  output logic                                frame_err,
  output logic                                new_data,
  output logic                                cts,
  output logic                                overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);
  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EW    = DATA_BITS + 2;

  logic                 sync1_q, sync2_q, rx_prev_q;
  logic                 rx, rx_fall, tick;
  rx_state_t            state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [3:0]           tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push, push_ferr, push_perr;
  logic                 fifo_full, fifo_empty;
  logic [EW-1:0]        fifo_rdata;
  logic                 overrun_q, overrun_d;
  logic                 cts_q, cts_d;

  assign rx      = sync2_q;
  assign rx_fall = rx_prev_q & ~sync2_q;
  assign tick    = (div_q == DIV_W'(DIV - 1));

`ifdef UART_RX_PARITY_EN
  parity_mode_t pmode_q, pmode_d;
  logic         perr_q, perr_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pmode_q <= PAR_NONE;
      perr_q  <= 1'b0;
    end else begin
      pmode_q <= pmode_d;
      perr_q  <= perr_d;
    end
  end

  assign push_perr  = perr_q;
  assign parity_err = fifo_rdata[1];
`else
  logic unused_parity;
  assign unused_parity = ^{parity_mode, fifo_rdata[1]};
  assign push_perr     = 1'b0;
  assign parity_err    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    push_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    pmode_d   = pmode_q;
    perr_d    = perr_q;
`endif
    if (state_q != ST_IDLE) div_d = tick ? '0 : div_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        // Divider restarts on the edge so ticks are phase-aligned to the frame.
        div_d  = '0;
        tick_d = '0;
        bit_d  = '0;
`ifdef UART_RX_PARITY_EN
        perr_d = 1'b0;
`endif
        if (rx_fall) state_d = ST_START;
      end
      ST_START: begin
        if (tick) begin
          if (tick_q == 4'(START_SAMPLE_TICK)) begin
            tick_d = '0;
            if (!rx) begin
              state_d = ST_DATA;
`ifdef UART_RX_PARITY_EN
              pmode_d = parity_mode_t'(parity_mode);
`endif
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == 4'd15) begin
            shift_d = {rx, shift_q[DATA_BITS-1:1]};
            if (bit_q == 4'(DATA_BITS - 1)) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = (pmode_q == PAR_EVEN || pmode_q == PAR_ODD) ? ST_PARITY : ST_STOP;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == 4'd15) begin
            perr_d  = (^shift_q ^ rx) ^ (pmode_q == PAR_ODD);
            state_d = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          tick_d = tick_q + 1'b1;
          if (tick_q == 4'd15) begin
            push      = 1'b1;
            push_ferr = ~rx;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (clear_err) overrun_d = 1'b0;
    // A drop takes priority over a simultaneous clear.
    if (push && fifo_full && !data_read) overrun_d = 1'b1;
    cts_d = (FIFO_DEPTH - int'(count)) > CTS_MARGIN;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      div_q     <= '0;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
      cts_q     <= 1'b1;
    end else begin
      sync1_q   <= serial_in;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
      cts_q     <= cts_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata ({shift_q, push_perr, push_ferr}),
    .pop   (data_read),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign data_out  = fifo_rdata[EW-1:2];
  assign frame_err = fifo_rdata[0];
  assign new_data  = ~fifo_empty;
  assign overrun   = overrun_q;
  assign cts       = cts_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, multi-cycle
// corner sequences and randomized frames against a queue-based model.
module tb_uart_rx_fifo;
  localparam int CLK_HZ     = 1600000;
  localparam int BAUD       = 10000;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CTS_MARGIN = 1;
  localparam int BIT_CLKS   = CLK_HZ / BAUD;
  // Line edge to mid-bit sample: 2 sync flops + edge detect + 8 ticks of 10.
  localparam int SAMPLE_AT  = 83;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic [1:0] parity_mode = 2'b00;
  logic       data_read = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] data_out;
  logic       parity_err, frame_err, new_data, cts, overrun;
  logic [2:0] count;

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH), .CTS_MARGIN(CTS_MARGIN)
  ) dut (
    .clock(clock), .reset(reset), .serial_in(serial_in), .parity_mode(parity_mode),
    .data_read(data_read), .clear_err(clear_err), .data_out(data_out),
    .parity_err(parity_err), .frame_err(frame_err), .new_data(new_data),
    .cts(cts), .overrun(overrun), .count(count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] d;
    logic [1:0] mode;
    bit         pbit;
    bit         stop;
    logic [7:0] exp_d;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    bit         perr;
    bit         ferr;
  } ent_t;

  vec_t vecs[7];
  ent_t q[$];
  ent_t shown;
  bit   exp_ovr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives one frame; returns one cycle after the receiver's stop sample.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input bit pbit,
                            input bit stop_bit, input bit read_at_stop, output int pre_count);
    parity_mode = mode;
    @(posedge clock); #1;
    serial_in = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      cycles(BIT_CLKS);
      serial_in = d[i];
    end
    if (PEN && (mode == 2'b01 || mode == 2'b10)) begin
      cycles(BIT_CLKS);
      serial_in = pbit;
    end
    cycles(BIT_CLKS);
    serial_in = stop_bit;
    cycles(SAMPLE_AT - 1);
    pre_count = int'(count);
    if (read_at_stop) data_read = 1'b1;
    cycles(1);
    data_read = 1'b0;
    $display("frame data=%02h mode=%0d pbit=%0d stop=%0d rd=%0d -> data_out=%02h pe=%0d fe=%0d count=%0d ovr=%0d",
             d, mode, pbit, stop_bit, read_at_stop, data_out, parity_err, frame_err, count, overrun);
  endtask

  task automatic finish_frame();
    cycles(BIT_CLKS - SAMPLE_AT);
    serial_in = 1'b1;
    cycles(16);
  endtask

  task automatic pulse_read();
    @(posedge clock); #1;
    data_read = 1'b1;
    cycles(1);
    data_read = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_data"}, int'(data_out), int'(shown.d));
    chk({tag, "_perr"}, int'(parity_err), int'(shown.perr));
    chk({tag, "_ferr"}, int'(frame_err), int'(shown.ferr));
    chk({tag, "_new"}, int'(new_data), (q.size() > 0) ? 1 : 0);
    chk({tag, "_count"}, int'(count), q.size());
    chk({tag, "_ovr"}, int'(overrun), int'(exp_ovr));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre;
    logic [7:0] ch[6];
    logic [7:0] d;
    logic [1:0] mode;
    bit pbit, stop, ep;
    int ones;

    vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 2'b01, 1'b1, 1'b1, 8'h03, PEN,  1'b0};
    vecs[2] = '{8'h03, 2'b01, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[3] = '{8'h55, 2'b00, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 2'b10, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 2'b10, 1'b1, 1'b1, 8'h80, PEN,  1'b0};
    vecs[6] = '{8'hFF, 2'b11, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    ch = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};

    // Reset values
    cycles(3);
    chk("rst_data", int'(data_out), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_new", int'(new_data), 0);
    chk("rst_cts", int'(cts), 1);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_pe", int'(parity_err), 0);
    chk("rst_fe", int'(frame_err), 0);
    reset = 1'b0;
    cycles(20);

    // Directed vector table: one frame in, check head, drain, read while empty
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].d, vecs[v].mode, vecs[v].pbit, vecs[v].stop, 1'b0, pre);
      chk("vec_pre_count", pre, 0);
      chk("vec_data", int'(data_out), int'(vecs[v].exp_d));
      chk("vec_perr", int'(parity_err), int'(vecs[v].exp_perr));
      chk("vec_ferr", int'(frame_err), int'(vecs[v].exp_ferr));
      chk("vec_new", int'(new_data), 1);
      chk("vec_count", int'(count), 1);
      finish_frame();
      pulse_read();
      chk("vec_pop_count", int'(count), 0);
      chk("vec_pop_new", int'(new_data), 0);
      pulse_read();
      chk("vec_empty_read_data", int'(data_out), int'(vecs[v].exp_d));
      chk("vec_empty_read_count", int'(count), 0);
    end

    // Short low glitch on an idle line must not produce a character
    @(posedge clock); #1;
    serial_in = 1'b0;
    cycles(40);
    serial_in = 1'b1;
    cycles(300);
    $display("glitch: count=%0d new_data=%0d", count, new_data);
    chk("glitch_count", int'(count), 0);
    chk("glitch_new", int'(new_data), 0);
    send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b0, pre);
    chk("after_glitch_data", int'(data_out), 8'hC3);
    chk("after_glitch_count", int'(count), 1);
    finish_frame();

    // Reset in the middle of data bit 3 discards everything
    @(posedge clock); #1;
    serial_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycles(BIT_CLKS);
      serial_in = 1'b0;
    end
    cycles(BIT_CLKS / 2);
    reset = 1'b1;
    serial_in = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(1);
    $display("mid-frame reset: count=%0d data_out=%02h", count, data_out);
    chk("midrst_count", int'(count), 0);
    chk("midrst_new", int'(new_data), 0);
    chk("midrst_data", int'(data_out), 0);
    chk("midrst_cts", int'(cts), 1);
    cycles(30);
    chk("midrst_idle_count", int'(count), 0);
    send_frame(8'h7E, 2'b00, 1'b0, 1'b1, 1'b0, pre);
    chk("post_rst_data", int'(data_out), 8'h7E);
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_fe", int'(frame_err), 0);
    finish_frame();
    pulse_read();
    cycles(2);

    // Fill to full, overflow, clear, then push coincident with pop when full
    for (int i = 0; i < 5; i++) begin
      send_frame(ch[i], 2'b00, 1'b0, 1'b1, 1'b0, pre);
      chk("fill_count", int'(count), (i + 1 > FIFO_DEPTH) ? FIFO_DEPTH : i + 1);
      chk("fill_ovr", int'(overrun), (i == 4) ? 1 : 0);
      if (i == 2) begin
        chk("cts_lag", int'(cts), 1);
        cycles(1);
        chk("cts_low_3", int'(cts), 0);
      end
      if (i == 1) begin
        cycles(1);
        chk("cts_high_2", int'(cts), 1);
      end
      finish_frame();
    end
    chk("full_head", int'(data_out), int'(ch[0]));
    @(posedge clock); #1;
    clear_err = 1'b1;
    cycles(1);
    clear_err = 1'b0;
    chk("clear_ovr", int'(overrun), 0);

    send_frame(ch[5], 2'b00, 1'b0, 1'b1, 1'b1, pre);
    chk("coinc_pre_count", pre, 4);
    chk("coinc_count", int'(count), 4);
    chk("coinc_ovr", int'(overrun), 0);
    chk("coinc_head", int'(data_out), int'(ch[1]));
    finish_frame();
    pulse_read();
    chk("drain_1", int'(data_out), int'(ch[2]));
    pulse_read();
    chk("drain_2", int'(data_out), int'(ch[3]));
    pulse_read();
    chk("drain_3_tail", int'(data_out), int'(ch[5]));
    pulse_read();
    chk("drain_empty_count", int'(count), 0);
    chk("drain_empty_hold", int'(data_out), int'(ch[5]));
    cycles(1);
    chk("drain_cts", int'(cts), 1);

    // Randomized frames against the queue model
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(5);
    q.delete();
    shown = '{8'h00, 1'b0, 1'b0};
    exp_ovr = 1'b0;
    check_model("rnd_reset");
    for (int n = 0; n < 14; n++) begin
      int npop;
      npop = int'($urandom_range(0, 2));
      for (int k = 0; k < npop; k++) begin
        pulse_read();
        if (q.size() > 0) begin
          void'(q.pop_front());
          if (q.size() > 0) shown = q[0];
        end
        check_model("rnd_pop");
      end
      d    = 8'($urandom_range(0, 255));
      mode = 2'($urandom_range(0, 3));
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      ep   = 1'b0;
      if (PEN && (mode == 2'b01 || mode == 2'b10)) begin
        ones = $countones(d) + int'(pbit);
        ep = (mode == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0);
      end
      send_frame(d, mode, pbit, stop, 1'b0, pre);
      if (q.size() == FIFO_DEPTH) exp_ovr = 1'b1;
      else begin
        q.push_back('{d, ep, !stop});
        if (q.size() == 1) shown = q[0];
      end
      check_model("rnd_rx");
      finish_frame();
      chk("rnd_cts", int'(cts), ((FIFO_DEPTH - q.size()) > CTS_MARGIN) ? 1 : 0);
      if (exp_ovr && ($urandom_range(0, 1) == 1)) begin
        @(posedge clock); #1;
        clear_err = 1'b1;
        cycles(1);
        clear_err = 1'b0;
        exp_ovr = 1'b0;
        chk("rnd_clear_ovr", int'(overrun), 0);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
